// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store sequencer.
//   lsu_state_e : sequencer state (IDLE / ACCESS / RESP)
//   lsu_size_e  : access size (byte / halfword / word)
//   BE_B/BE_H/BE_W : byte-lane masks for an access at offset 0
//   is_aligned()   : natural-alignment check for a size and byte offset
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } lsu_size_e;

   localparam logic [3:0] BE_B = 4'b0001;
   localparam logic [3:0] BE_H = 4'b0011;
   localparam logic [3:0] BE_W = 4'b1111;

   function automatic logic is_aligned(input lsu_size_e size, input logic [1:0] off);
      logic ok;
      case (size)
         SZ_H:    ok = (off[0] == 1'b0);
         SZ_W:    ok = (off == 2'b00);
         default: ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the load/store sequencer.
// Ports:
//   size        in   access size
//   offset      in   byte offset within the word (addr[1:0])
//   ld_unsigned in   zero-extend (1) or sign-extend (0) loads
//   wdata       in   store data, low bits significant
//   rdata       in   raw word read from memory
//   be          out  byte-lane enables for the bus
//   wdata_lane  out  store data replicated onto every lane it could occupy
//   rdata_ext   out  load data shifted down to bit 0 and extended
module lsu_align
   import lsu_pkg::*;
(
   input  lsu_size_e   size,
   input  logic [1:0]  offset,
   input  logic        ld_unsigned,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_ext
);

   logic [31:0] shifted;

   always_comb begin
      // Bring the addressed byte/halfword down to bit 0 before extending.
      shifted    = rdata >> {offset, 3'b000};
      be         = BE_W;
      wdata_lane = wdata;
      rdata_ext  = shifted;
      case (size)
         SZ_B: begin
            be         = BE_B << offset;
            wdata_lane = {4{wdata[7:0]}};
            rdata_ext  = {{24{~ld_unsigned & shifted[7]}}, shifted[7:0]};
         end
         SZ_H: begin
            be         = BE_H << offset;
            wdata_lane = {2{wdata[15:0]}};
            rdata_ext  = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
         end
         default: begin
            be         = BE_W;
            wdata_lane = wdata;
            rdata_ext  = shifted;
         end
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between decode enables and a single-port
// data-memory bus with a req/ready handshake.
//
// Handshake: mem_req is high for every ACCESS cycle and all bus outputs stay
// stable until the cycle in which mem_ready is seen high; that cycle completes
// the transfer. mem_ready is ignored outside ACCESS.
//
// Optional feature (macro LSU_TIMEOUT_EN): abort an ACCESS that has waited
// TIMEOUT cycles without mem_ready and pulse bus_err. Without the macro the
// bus is waited on indefinitely and bus_err is tied low.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   lb/lh/lw/sb/sh/sw_en            one-hot access request (lw>lh>lb>sw>sh>sb)
//   ld_unsigned                     zero-extend load result
//   addr, wdata                     effective byte address, store data
//   mem_req/we/be/addr/wdata        bus request outputs (registered)
//   mem_rdata, mem_ready            bus response
//   stall                           hold upstream pipeline
//   rd_data, rd_valid               load write-back data and one-cycle strobe
//   misalign, bus_err               one-cycle fault pulses
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            lb_en,
   input  logic            lh_en,
   input  logic            lw_en,
   input  logic            sb_en,
   input  logic            sh_en,
   input  logic            sw_en,
   input  logic            ld_unsigned,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wdata,
   output logic            mem_req,
   output logic            mem_we,
   output logic [3:0]      mem_be,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ready,
   output logic            stall,
   output logic [XLEN-1:0] rd_data,
   output logic            rd_valid,
   output logic            misalign,
   output logic            bus_err
);

   lsu_state_e state, state_next;

   // Request decode
   logic      req_any;
   logic      req_we;
   lsu_size_e req_size;
   logic      req_aligned;
   logic      accept;
   logic      reject;

   // Registered access attributes needed while the access is in flight
   lsu_size_e size_q;
   logic [1:0] off_q;
   logic       uns_q;

   // Lane steering
   lsu_size_e   al_size;
   logic [1:0]  al_off;
   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic [31:0] al_rdata;

   logic access_done;
   logic timed_out;

   always_comb begin
      req_any  = lb_en | lh_en | lw_en | sb_en | sh_en | sw_en;
      req_size = SZ_B;
      req_we   = 1'b0;
      if (lw_en) begin
         req_size = SZ_W;
      end else if (lh_en) begin
         req_size = SZ_H;
      end else if (lb_en) begin
         req_size = SZ_B;
      end else if (sw_en) begin
         req_size = SZ_W;
         req_we   = 1'b1;
      end else if (sh_en) begin
         req_size = SZ_H;
         req_we   = 1'b1;
      end else if (sb_en) begin
         req_size = SZ_B;
         req_we   = 1'b1;
      end
   end

   assign req_aligned = is_aligned(req_size, addr[1:0]);
   assign accept      = (state == IDLE) & req_any & req_aligned;
   assign reject      = (state == IDLE) & req_any & ~req_aligned;

   // One steering block serves both directions: in IDLE it shapes the incoming
   // store lanes/strobes, in ACCESS it extends the returning load word using
   // the attributes captured at accept time.
   assign al_size = (state == IDLE) ? req_size : size_q;
   assign al_off  = (state == IDLE) ? addr[1:0] : off_q;

   lsu_align u_align (
      .size        (al_size),
      .offset      (al_off),
      .ld_unsigned (uns_q),
      .wdata       (wdata),
      .rdata       (mem_rdata),
      .be          (al_be),
      .wdata_lane  (al_wdata),
      .rdata_ext   (al_rdata)
   );

   assign access_done = (state == ACCESS) & mem_ready;

`ifdef LSU_TIMEOUT_EN
   localparam logic [3:0] TMO = TIMEOUT[3:0];

   logic [3:0] wait_cnt;
   logic       bus_err_q;

   // mem_ready in the same cycle takes precedence over the timeout.
   assign timed_out = (state == ACCESS) & ~mem_ready & (wait_cnt == TMO);

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt  <= 4'd0;
         bus_err_q <= 1'b0;
      end else begin
         bus_err_q <= timed_out;
         if (accept) begin
            wait_cnt <= 4'd0;
         end else if ((state == ACCESS) && !mem_ready) begin
            wait_cnt <= wait_cnt + 4'd1;
         end
      end
   end

   assign bus_err = bus_err_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT[3:0];
   assign timed_out      = 1'b0;
   assign bus_err        = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) state_next = ACCESS;
         end
         ACCESS: begin
            if (access_done) begin
               state_next = mem_we ? IDLE : RESP;
            end else if (timed_out) begin
               state_next = IDLE;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign mem_req  = (state == ACCESS);
   assign rd_valid = (state == RESP);
   // Combinational so the pipeline freezes in the same cycle the request
   // is presented; a misaligned request never stalls.
   assign stall    = accept | (state != IDLE);

   // Bus attributes, load result and fault pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_we    <= 1'b0;
         mem_be    <= 4'b0000;
         mem_addr  <= '0;
         mem_wdata <= '0;
         size_q    <= SZ_B;
         off_q     <= 2'b00;
         uns_q     <= 1'b0;
         rd_data   <= '0;
         misalign  <= 1'b0;
      end else begin
         misalign <= reject;
         if (accept) begin
            mem_we    <= req_we;
            mem_be    <= al_be;
            mem_addr  <= {addr[XLEN-1:2], 2'b00};
            mem_wdata <= al_wdata;
            size_q    <= req_size;
            off_q     <= addr[1:0];
            uns_q     <= ld_unsigned;
         end
         if (access_done && !mem_we) begin
            rd_data <= al_rdata;
         end
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl. Directed cases followed by
// randomized accesses, each checked cycle by cycle against a byte-level model
// of the bus transaction and load extension. Build with +define+LSU_TIMEOUT_EN
// to exercise the timeout path instead of the indefinite wait.
module tb_lsu_ctrl;

   logic        clk;
   logic        rst;
   logic        lb_en, lh_en, lw_en, sb_en, sh_en, sw_en;
   logic        ld_unsigned;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        stall;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        misalign;
   logic        bus_err;

   int n_total = 0;
   int n_bad   = 0;

   logic [31:0] exp_q[$];
   logic [31:0] last_rd;

   lsu_ctrl #(.XLEN(32), .TIMEOUT(15)) dut (
      .clk         (clk),
      .rst         (rst),
      .lb_en       (lb_en),
      .lh_en       (lh_en),
      .lw_en       (lw_en),
      .sb_en       (sb_en),
      .sh_en       (sh_en),
      .sw_en       (sw_en),
      .ld_unsigned (ld_unsigned),
      .addr        (addr),
      .wdata       (wdata),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_be      (mem_be),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready),
      .stall       (stall),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .misalign    (misalign),
      .bus_err     (bus_err)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checker ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Operation index: 0=lb 1=lh 2=lw 3=sb 4=sh 5=sw (also the enable bit).
   function automatic int pick_op(input logic [5:0] mask);
      if (mask[2]) return 2;
      if (mask[1]) return 1;
      if (mask[0]) return 0;
      if (mask[5]) return 5;
      if (mask[4]) return 4;
      return 3;
   endfunction

   function automatic int op_bytes(input int op);
      case (op % 3)
         0:       return 1;
         1:       return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] model_wdata(input int nb, input logic [31:0] wd);
      logic [31:0] r;
      if (nb == 1)      r = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      else if (nb == 2) r = {wd[15:0], wd[15:0]};
      else              r = wd;
      return r;
   endfunction

   function automatic logic [31:0] model_load(input int nb, input int off,
                                              input logic uns, input logic [31:0] word);
      logic [31:0] v;
      v = word >> (8 * off);
      if (nb == 1) begin
         v = v & 32'h0000_00FF;
         if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (nb == 2) begin
         v = v & 32'h0000_FFFF;
         if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   // ---------------- driver ----------------
   task automatic idle_inputs();
      {sw_en, sh_en, sb_en, lw_en, lh_en, lb_en} = 6'b0;
      addr        = $urandom;
      wdata       = $urandom;
      ld_unsigned = 1'($urandom_range(0, 1));
   endtask

   // Runs one complete request and checks every cycle of it.
   task automatic run_op(input logic [5:0] mask, input logic [31:0] a, input logic [31:0] wd,
                         input logic uns, input int waits, input logic [31:0] rword);
      int          op, nb, off, stall_cnt, exp_stall;
      logic        is_ld, ok;
      logic [3:0]  ebe;
      logic [31:0] ewd, eaddr, got_exp;
      op        = pick_op(mask);
      nb        = op_bytes(op);
      off       = int'(a[1:0]);
      is_ld     = (op < 3);
      ok        = ((off % nb) == 0);
      ebe       = 4'(((1 << nb) - 1) << off);
      ewd       = model_wdata(nb, wd);
      eaddr     = a & 32'hFFFF_FFFC;
      exp_stall = !ok ? 0 : (is_ld ? 3 + waits : 2 + waits);
      if (ok && is_ld) exp_q.push_back(model_load(nb, off, uns, rword));
      stall_cnt = 0;

      @(negedge clk);
      {sw_en, sh_en, sb_en, lw_en, lh_en, lb_en} = mask;
      addr        = a;
      wdata       = wd;
      ld_unsigned = uns;
      mem_ready   = 1'($urandom_range(0, 1));
      mem_rdata   = $urandom;
      #1;
      chk("req_stall", 32'(stall), 32'(ok));
      chk("req_memreq", 32'(mem_req), 0);
      if (stall) stall_cnt++;

      if (!ok) begin
         @(negedge clk);
         idle_inputs();
         mem_ready = 1'($urandom_range(0, 1));
         #1;
         chk("mis_pulse", 32'(misalign), 1);
         chk("mis_memreq", 32'(mem_req), 0);
         chk("mis_stall", 32'(stall), 0);
         @(negedge clk);
         #1;
         chk("mis_clear", 32'(misalign), 0);
         chk("mis_memreq2", 32'(mem_req), 0);
      end else begin
         for (int k = 0; k <= waits; k++) begin
            @(negedge clk);
            idle_inputs();
            mem_ready = (k == waits);
            mem_rdata = (k == waits) ? rword : $urandom;
            #1;
            chk("acc_req", 32'(mem_req), 1);
            chk("acc_we", 32'(mem_we), 32'(!is_ld));
            chk("acc_be", 32'(mem_be), 32'(ebe));
            chk("acc_addr", mem_addr, eaddr);
            if (!is_ld) chk("acc_wdata", mem_wdata, ewd);
            chk("acc_rdvalid", 32'(rd_valid), 0);
            chk("acc_mis", 32'(misalign), 0);
            chk("acc_buserr", 32'(bus_err), 0);
            if (stall) stall_cnt++;
         end
         if (is_ld) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            #1;
            chk("resp_valid", 32'(rd_valid), 1);
            chk("resp_req", 32'(mem_req), 0);
            if (exp_q.size() == 0) begin
               chk("resp_sb_empty", 1, 0);
            end else begin
               got_exp = exp_q.pop_front();
               chk("resp_data", rd_data, got_exp);
               last_rd = got_exp;
            end
            if (stall) stall_cnt++;
         end
         @(negedge clk);
         mem_ready = 1'($urandom_range(0, 1));
         #1;
         chk("done_req", 32'(mem_req), 0);
         chk("done_valid", 32'(rd_valid), 0);
         chk("done_stall", 32'(stall), 0);
      end
      chk("rd_hold", rd_data, last_rd);
      chk("stall_cnt", stall_cnt, exp_stall);
      mem_ready = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [5:0] mask;
      rst = 1'b1;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      idle_inputs();
      last_rd = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req", 32'(mem_req), 0);
      chk("rst_we", 32'(mem_we), 0);
      chk("rst_be", 32'(mem_be), 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_rd", rd_data, 0);
      chk("rst_valid", 32'(rd_valid), 0);
      chk("rst_mis", 32'(misalign), 0);
      chk("rst_buserr", 32'(bus_err), 0);
      chk("rst_stall", 32'(stall), 0);
      @(negedge clk);
      rst = 1'b0;

      // Directed cases
      run_op(6'b000100, 32'h0000_0100, 32'h0, 1'b0, 0, 32'hDEAD_BEEF);
      run_op(6'b000001, 32'h0000_0103, 32'h0, 1'b0, 0, 32'h80FF_0000);
      run_op(6'b000001, 32'h0000_0103, 32'h0, 1'b1, 0, 32'h80FF_0000);
      run_op(6'b010000, 32'h0000_0202, 32'h1234_ABCD, 1'b0, 3, 32'h0);
      run_op(6'b000100, 32'h0000_0101, 32'h0, 1'b0, 0, 32'h0);
      run_op(6'b000010, 32'h0000_0103, 32'h0, 1'b0, 0, 32'h0);
      run_op(6'b001000, 32'h0000_0301, 32'h0000_00A5, 1'b0, 1, 32'h0);
      run_op(6'b100000, 32'h0000_0400, 32'hCAFE_F00D, 1'b0, 0, 32'h0);
      run_op(6'b000010, 32'h0000_0502, 32'h0, 1'b0, 2, 32'h8001_7FFF);
      run_op(6'b111111, 32'h0000_0600, 32'h0, 1'b0, 0, 32'h1357_9BDF);

      // Reset during the second ACCESS cycle of a load
      @(negedge clk);
      lw_en = 1'b1;
      addr  = 32'h0000_0040;
      mem_ready = 1'b0;
      #1 chk("rr_stall", 32'(stall), 1);
      @(negedge clk);
      idle_inputs();
      #1 chk("rr_acc1", 32'(mem_req), 1);
      @(negedge clk);
      rst = 1'b1;
      #1 chk("rr_acc2", 32'(mem_req), 1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rr_req", 32'(mem_req), 0);
      chk("rr_stall0", 32'(stall), 0);
      chk("rr_valid", 32'(rd_valid), 0);
      chk("rr_be", 32'(mem_be), 0);
      chk("rr_rd", rd_data, 0);
      last_rd = 32'h0;
      @(negedge clk);
      #1;
      chk("rr_valid2", 32'(rd_valid), 0);
      chk("rr_mis", 32'(misalign), 0);
      chk("rr_buserr", 32'(bus_err), 0);
      run_op(6'b000100, 32'h0000_0044, 32'h0, 1'b0, 1, 32'h0BAD_F00D);

      // Bus that never answers
      @(negedge clk);
      lw_en = 1'b1;
      addr  = 32'h0000_0080;
      mem_ready = 1'b0;
      #1 chk("hang_stall", 32'(stall), 1);
`ifdef LSU_TIMEOUT_EN
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         idle_inputs();
         mem_ready = 1'b0;
         #1;
         chk("tmo_req", 32'(mem_req), 1);
         chk("tmo_err0", 32'(bus_err), 0);
      end
      @(negedge clk);
      #1;
      chk("tmo_err", 32'(bus_err), 1);
      chk("tmo_req0", 32'(mem_req), 0);
      chk("tmo_stall", 32'(stall), 0);
      chk("tmo_valid", 32'(rd_valid), 0);
      @(negedge clk);
      #1;
      chk("tmo_err_clr", 32'(bus_err), 0);
      chk("tmo_valid2", 32'(rd_valid), 0);
`else
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         idle_inputs();
         mem_ready = 1'b0;
         #1;
         chk("wait_req", 32'(mem_req), 1);
         chk("wait_err", 32'(bus_err), 0);
         chk("wait_stall", 32'(stall), 1);
      end
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = 32'h1234_5678;
      #1 chk("wait_req_end", 32'(mem_req), 1);
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      chk("wait_valid", 32'(rd_valid), 1);
      chk("wait_rd", rd_data, 32'h1234_5678);
      last_rd = 32'h1234_5678;
      @(negedge clk);
      #1 chk("wait_stall0", 32'(stall), 0);
`endif

      // Randomized accesses
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) mask = 6'($urandom_range(1, 63));
         else                           mask = 6'(1 << $urandom_range(0, 5));
         run_op(mask, $urandom, $urandom, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom);
      end

      chk("sb_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store sequencer between the decode enables (lb/lh/lw/sb/sh/sw) and a single-port data-memory bus with a req/ready handshake.
- Converts one access into a word-aligned bus transaction with byte-lane strobes.
- Holds the pipeline with `stall` until the access completes.
- Aligns and sign/zero-extends load data for register write-back.
- Flags misaligned accesses instead of issuing them.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- TIMEOUT, 15, max cycles in ACCESS waiting for mem_ready before bus error (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- lb_en  in  1  load byte request
- lh_en  in  1  load halfword request
- lw_en  in  1  load word request
- sb_en  in  1  store byte request
- sh_en  in  1  store halfword request
- sw_en  in  1  store word request
- ld_unsigned  in  1  zero-extend load (func3[2])
- addr  in  XLEN  effective byte address
- wdata  in  XLEN  store data (rs2), low bits significant
- mem_req  out  1  bus request
- mem_we  out  1  1=write, 0=read
- mem_be  out  4  byte-lane enables
- mem_addr  out  XLEN  word address, {addr[31:2],2'b00}
- mem_wdata  out  XLEN  store data replicated/shifted to lanes
- mem_rdata  in  XLEN  read data, valid when mem_ready
- mem_ready  in  1  bus completes the current request
- stall  out  1  freeze upstream pipeline
- rd_data  out  XLEN  extended load result
- rd_valid  out  1  one-cycle write-back strobe for loads
- misalign  out  1  one-cycle fault pulse
- bus_err  out  1  one-cycle timeout pulse (0 when feature is off)

Behaviour:
Reset values: state=IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, rd_data, rd_valid, misalign and bus_err all 0.

States: IDLE, ACCESS, RESP.

Request selection:
- Only one enable may be active at a time.
- If several are active, priority is lw>lh>lb>sw>sh>sb.
- Requests are sampled only in IDLE and ignored in other states.

Alignment check:
- Halfword requires addr[0]=0.
- Word requires addr[1:0]=0.
- Byte is always aligned.

IDLE, misaligned request:
- misaligned pulses for one cycle at the next edge.
- No bus activity; stay in IDLE.
- stall is never raised for a misaligned access.

IDLE, aligned request:
- Registers mem_addr, mem_we, mem_be, mem_wdata, size and ld_unsigned; goes to ACCESS.
- stall is combinational high in that same cycle: stall = (state==IDLE & aligned request) | (state!=IDLE).

Lane rules:
- Byte: be = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
- Halfword: be = 0011 << addr[1:0]; wdata = {2{wdata[15:0]}}.
- Word: be = 1111; wdata passed through.

ACCESS:
- mem_req=1, with all bus outputs held stable until mem_ready.
- On mem_ready, store: next edge drops mem_req and returns to IDLE.
- On mem_ready, load: rd_data is set to mem_rdata shifted right by 8*addr[1:0], then sign- or zero-extended per size and ld_unsigned. Go to RESP.
- mem_ready is sampled only in ACCESS.

RESP:
- rd_valid=1 for exactly one cycle, stall=1, then IDLE.
- rd_data holds its value until the next load completes.

Latency with zero-wait memory (mem_ready high on the first ACCESS cycle):
- Store: 2 stall cycles.
- Load: 3 stall cycles.

Reset mid-operation:
- State goes to IDLE and mem_req falls on the same edge.
- No rd_valid, misalign or bus_err is produced.

Back-to-back: a new request is accepted in the first IDLE cycle after completion.

Optional Feature:
Macro: LSU_TIMEOUT_EN.

Defined:
- A 4-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle without mem_ready.
- When count==TIMEOUT and mem_ready=0: drop mem_req, pulse bus_err for one cycle, return to IDLE, no rd_valid.
- mem_ready on the same cycle wins over timeout.

Undefined:
- ACCESS waits indefinitely.
- bus_err is tied to 0 and no counter exists.

Decomposition:
Shared package `lsu_pkg`:
- state enum (IDLE/ACCESS/RESP).
- size enum (SZ_B/SZ_H/SZ_W).
- BE_B/BE_H/BE_W constants.

Sub-module `lsu_align`:
- Purely combinational.
- Input: size, offset, ld_unsigned, wdata, rdata.
- Output: be, lane-replicated wdata, extended rdata.
- lsu_ctrl holds the FSM and registers.

Test Plan:
1. lw_en, addr=0x100, mem_rdata=0xDEADBEEF, ready on first ACCESS cycle -> mem_addr=0x100, be=1111, rd_data=0xDEADBEEF, rd_valid one cycle, stall high exactly 3 cycles.
2. lb_en, addr=0x103, mem_rdata=0x80FF_0000 -> be=1000, rd_data=0xFFFFFF80. Repeat with ld_unsigned=1 -> rd_data=0x00000080.
3. sh_en, addr=0x202, wdata=0x1234ABCD, ready after 3 wait cycles -> mem_we=1, be=1100, mem_wdata=0xABCDABCD held stable for 4 cycles, stall high 5 cycles, no rd_valid.
4. lw_en, addr=0x101 -> misalign pulse, mem_req never rises, stall stays 0. lh_en, addr=0x103 -> same result.
5. rst asserted in second ACCESS cycle of a load -> mem_req=0 and state IDLE next cycle; no rd_valid; next request proceeds normally.
6. With LSU_TIMEOUT_EN, mem_ready held 0 -> bus_err pulses after 15 ACCESS cycles, mem_req drops, stall falls. Without the macro -> mem_req held for 100 cycles, bus_err=0.
